// File: rtl/flow_fifo_if.sv
// flow_fifo_if: lane handshake bundle between the data-flow controller and one flow_fifo.
// Latency: none (wires only); the FIFO side owns all registers.
// Backpressure: status flags and fifo_pause travel FIFO -> controller alongside the strobes.
interface flow_fifo_if #(
  parameter int DATA_WIDTH = 6
) ();
  logic                  write;
  logic                  read;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  Fifo_full;
  logic                  almost_full;
  logic                  fifo_empty;
  logic                  almost_empty;
  logic                  fifo_error;
  logic                  fifo_pause;

  // Controller side: issues strobes and write data, consumes status.
  modport master (
    output write, read, data_in,
    input  data_out, valid_out, Fifo_full, almost_full,
    input  fifo_empty, almost_empty, fifo_error, fifo_pause
  );

  // FIFO side: consumes strobes, drives read data and status.
  modport slave (
    input  write, read, data_in,
    output data_out, valid_out, Fifo_full, almost_full,
    output fifo_empty, almost_empty, fifo_error, fifo_pause
  );
endinterface

// File: rtl/flow_fifo.sv
// flow_fifo: per-lane synchronous FIFO with occupancy flags, overflow/underflow error and hysteretic pause.
// Latency: accepted read -> data_out/valid_out after 1 cycle; flags decode the registered count.
// Backpressure: fifo_pause sets at AF_THRESH and clears at AE_THRESH; a push at full is dropped unless a pop is accepted.
// Build option: define FLOW_FIFO_STICKY_ERR_EN to hold fifo_error until reset (default: one-cycle pulse).
module flow_fifo #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input logic        clk,
  input logic        reset,
  flow_fifo_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_CNT   = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_CNT   = AE_THRESH[ADDR_WIDTH:0];

  typedef enum logic {RUN, PAUSE} pause_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_nxt;
  pause_state_t          state;
  logic                  pop_acc;
  logic                  push_acc;
  logic                  err_ev;

  // A pop frees a slot in the same cycle, so a push at full still lands when paired with a pop.
  assign pop_acc  = bus.read & (count != '0);
  assign push_acc = bus.write & ((count != FULL_CNT) | pop_acc);
  assign err_ev   = (bus.write & ~push_acc) | (bus.read & (count == '0));

  // Occupancy after this edge; pause decisions look at this, not the current count.
  always_comb begin
    count_nxt = count;
    if (push_acc && !pop_acc) begin
      count_nxt = count + 1'b1;
    end else if (!push_acc && pop_acc) begin
      count_nxt = count - 1'b1;
    end
  end

  // Storage array: only accepted pushes write, so a dropped word never disturbs contents.
  always_ff @(posedge clk) begin
    if (reset && push_acc) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // Pointers, occupancy and registered read port; empty-cycle pushes are never bypassed to data_out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.data_out  <= '0;
      bus.valid_out <= 1'b0;
    end else begin
      count <= count_nxt;
      if (push_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_acc) begin
        bus.data_out <= mem[rd_ptr];
        rd_ptr       <= rd_ptr + 1'b1;
      end
      bus.valid_out <= pop_acc;
    end
  end

  // Error flag: sticky or single-cycle pulse depending on build.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.fifo_error <= 1'b0;
    end else begin
`ifdef FLOW_FIFO_STICKY_ERR_EN
      bus.fifo_error <= bus.fifo_error | err_ev;
`else
      bus.fifo_error <= err_ev;
`endif
    end
  end

  // Pause FSM: engages at the high-water mark, releases only at the low-water mark.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (count_nxt >= AF_CNT) state <= PAUSE;
        PAUSE:   if (count_nxt <= AE_CNT) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign bus.fifo_pause   = (state == PAUSE);
  assign bus.Fifo_full    = (count == FULL_CNT);
  assign bus.almost_full  = (count >= AF_CNT);
  assign bus.fifo_empty   = (count == '0);
  assign bus.almost_empty = (count <= AE_CNT);

endmodule

// File: tb/tb_flow_fifo.sv
// tb_flow_fifo: directed and randomized checks of flow_fifo against a queue-based reference model.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 time unit after posedge.
// Backpressure: the model derives accept/drop/pause purely from occupancy rules.
module tb_flow_fifo;

  localparam int DW    = 6;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;
`ifdef FLOW_FIFO_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  logic          m_vld;
  logic          m_err;
  logic          m_pause;

  flow_fifo_if #(.DATA_WIDTH(DW)) bus ();

  flow_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Drive one cycle of strobes, advance the model by the occupancy rules, then settle for sampling.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    bit pop;
    bit push;
    bit ev;
    bus.write   = w;
    bus.read    = r;
    bus.data_in = d;
    @(posedge clk);
    if (!reset) begin
      mq.delete();
      m_dout  = '0;
      m_vld   = 1'b0;
      m_err   = 1'b0;
      m_pause = 1'b0;
    end else begin
      pop  = r && (mq.size() > 0);
      push = w && ((mq.size() < DEPTH) || pop);
      ev   = (w && !push) || (r && mq.size() == 0);
      if (pop) begin
        m_dout = mq.pop_front();
        m_vld  = 1'b1;
      end else begin
        m_vld = 1'b0;
      end
      if (push) mq.push_back(d);
      m_err = STICKY ? (m_err | ev) : ev;
      if (mq.size() >= AF) m_pause = 1'b1;
      else if (mq.size() <= AE) m_pause = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(1'b1, 1'b1, 6'h3F);
    step(1'b1, 1'b1, 6'h3F);
    checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.fifo_empty); end
    checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty got %b exp 1", bus.almost_empty); end
    checks++; if (bus.fifo_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", bus.fifo_error); end
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.valid_out); end
    checks++; if (bus.fifo_pause !== 1'b0) begin errors++; $display("FAIL reset_pause got %b exp 0", bus.fifo_pause); end
    checks++; if ({bus.Fifo_full, bus.almost_full} !== 2'b00) begin errors++; $display("FAIL reset_full got %b exp 00", {bus.Fifo_full, bus.almost_full}); end
    checks++; if (bus.data_out !== 6'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", bus.data_out); end
    reset = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0, DW'(i));
      checks++; if (bus.almost_empty !== (i <= AE)) begin errors++; $display("FAIL fill_ae push %0d got %b exp %b", i, bus.almost_empty, (i <= AE)); end
      checks++; if (bus.almost_full !== (i >= AF)) begin errors++; $display("FAIL fill_af push %0d got %b exp %b", i, bus.almost_full, (i >= AF)); end
      checks++; if (bus.fifo_pause !== (i >= AF)) begin errors++; $display("FAIL fill_pause push %0d got %b exp %b", i, bus.fifo_pause, (i >= AF)); end
      checks++; if (bus.Fifo_full !== (i == DEPTH)) begin errors++; $display("FAIL fill_full push %0d got %b exp %b", i, bus.Fifo_full, (i == DEPTH)); end
      checks++; if (bus.fifo_empty !== 1'b0) begin errors++; $display("FAIL fill_empty push %0d got %b exp 0", i, bus.fifo_empty); end
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, 6'h09);
    checks++; if (bus.fifo_error !== 1'b1) begin errors++; $display("FAIL ovf_error got %b exp 1", bus.fifo_error); end
    checks++; if (bus.Fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", bus.Fifo_full); end
    step(1'b0, 1'b0, 6'h00);
    checks++; if (bus.fifo_error !== STICKY) begin errors++; $display("FAIL ovf_error_after got %b exp %b", bus.fifo_error, STICKY); end
  endtask

  task automatic test_drain();
    for (int k = 1; k <= DEPTH; k++) begin
      step(1'b0, 1'b1, 6'h00);
      checks++; if (bus.data_out !== DW'(k)) begin errors++; $display("FAIL drain_data pop %0d got %h exp %h", k, bus.data_out, DW'(k)); end
      checks++; if (bus.valid_out !== 1'b1) begin errors++; $display("FAIL drain_valid pop %0d got %b exp 1", k, bus.valid_out); end
      checks++; if (bus.fifo_pause !== ((DEPTH - k) > AE)) begin errors++; $display("FAIL drain_pause pop %0d got %b exp %b", k, bus.fifo_pause, ((DEPTH - k) > AE)); end
    end
    checks++; if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", bus.fifo_empty); end
    step(1'b0, 1'b0, 6'h00);
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL drain_idle_valid got %b exp 0", bus.valid_out); end
  endtask

  task automatic test_full_simul();
    logic [DW-1:0] words [DEPTH];
    for (int i = 0; i < DEPTH; i++) begin
      words[i] = DW'($urandom_range(0, 63));
      step(1'b1, 1'b0, words[i]);
    end
    step(1'b1, 1'b1, 6'h2A);
    checks++; if (bus.Fifo_full !== 1'b1) begin errors++; $display("FAIL simul_full got %b exp 1", bus.Fifo_full); end
    checks++; if (bus.data_out !== words[0]) begin errors++; $display("FAIL simul_data got %h exp %h", bus.data_out, words[0]); end
    checks++; if (bus.fifo_error !== m_err) begin errors++; $display("FAIL simul_error got %b exp %b", bus.fifo_error, m_err); end
    for (int i = 1; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 6'h00);
      checks++; if (bus.data_out !== words[i]) begin errors++; $display("FAIL simul_pop %0d got %h exp %h", i, bus.data_out, words[i]); end
    end
    step(1'b0, 1'b1, 6'h00);
    checks++; if (bus.data_out !== 6'h2A) begin errors++; $display("FAIL simul_wrap got %h exp 2a", bus.data_out); end
  endtask

  task automatic test_underflow();
    logic [DW-1:0] held;
    held = bus.data_out;
    step(1'b0, 1'b1, 6'h00);
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL udf_valid got %b exp 0", bus.valid_out); end
    checks++; if (bus.data_out !== held) begin errors++; $display("FAIL udf_data got %h exp %h", bus.data_out, held); end
    checks++; if (bus.fifo_error !== 1'b1) begin errors++; $display("FAIL udf_error got %b exp 1", bus.fifo_error); end
    // Push and pop together while empty: only the push lands, nothing bypasses.
    step(1'b1, 1'b1, 6'h15);
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL empty_rw_valid got %b exp 0", bus.valid_out); end
    checks++; if (bus.fifo_empty !== 1'b0) begin errors++; $display("FAIL empty_rw_empty got %b exp 0", bus.fifo_empty); end
    step(1'b0, 1'b1, 6'h00);
    checks++; if (bus.data_out !== 6'h15) begin errors++; $display("FAIL empty_rw_data got %h exp 15", bus.data_out); end
  endtask

  task automatic test_random();
    logic [12:0] got;
    logic [12:0] exp;
    reset = 1'b0;
    step(1'b0, 1'b0, 6'h00);
    reset = 1'b1;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) != 0);
      // Bias toward filling in the first half and draining in the second to sweep all flags.
      step(($urandom_range(0, 99) < ((n < 200) ? 70 : 35)),
           ($urandom_range(0, 99) < ((n < 200) ? 35 : 70)),
           DW'($urandom_range(0, 63)));
      got = {bus.data_out, bus.valid_out, bus.Fifo_full, bus.almost_full,
             bus.fifo_empty, bus.almost_empty, bus.fifo_error, bus.fifo_pause};
      exp = {m_dout, m_vld, (mq.size() == DEPTH), (mq.size() >= AF),
             (mq.size() == 0), (mq.size() <= AE), m_err, m_pause};
      checks++; if (got !== exp) begin errors++; $display("FAIL random cycle %0d got %b exp %b", n, got, exp); end
    end
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b1;
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.data_in = '0;
    m_dout      = '0;
    m_vld       = 1'b0;
    m_err       = 1'b0;
    m_pause     = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_full_simul();
    test_underflow();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flow_fifo.md
Name: flow_fifo

Overview:
- Synchronous FIFO with status flags for each lane of the switch datapath.
- Accepts the write/read strobes issued by the data-flow controller.
- Returns the full/almost_full/empty/almost_empty/error/pause status that the controller consumes.
- One instance per lane; two instances serve the two-lane controller.

Parameters:
- DATA_WIDTH, 6: width of data_in/data_out.
- ADDR_WIDTH, 3: pointer width; depth = 2**ADDR_WIDTH (8).
- AF_THRESH, 6: occupancy at or above which almost_full asserts and pause engages.
- AE_THRESH, 2: occupancy at or below which almost_empty asserts and pause releases.

Ports:
- clk  in  1  Single clock; all state updates on posedge.
- reset  in  1  Synchronous, active-low.
- write  in  1  Push request; data_in is captured when the push is accepted.
- read  in  1  Pop request.
- data_in  in  DATA_WIDTH  Write data.
- data_out  out  DATA_WIDTH  Registered read data.
- valid_out  out  1  data_out holds a word popped on the previous edge.
- Fifo_full  out  1  Occupancy == depth.
- almost_full  out  1  Occupancy >= AF_THRESH.
- fifo_empty  out  1  Occupancy == 0.
- almost_empty  out  1  Occupancy <= AE_THRESH.
- fifo_error  out  1  Overflow or underflow indication.
- fifo_pause  out  1  Hysteretic back-pressure to the upstream stage.

Behaviour:
- Reset is one clock and synchronous, active-low: reset==0 sampled at posedge clears all state:
  - wr_ptr=0, rd_ptr=0, count=0, pause FSM=RUN.
  - data_out=0, valid_out=0, fifo_error=0.
  - Resulting flags: fifo_empty=1, almost_empty=1, Fifo_full=0, almost_full=0, fifo_pause=0.
- Reset mid-operation discards all stored words; no partial pop is completed.
- State: memory of 2**ADDR_WIDTH words; wr_ptr/rd_ptr ADDR_WIDTH bits, natural wrap from depth-1 to 0; count ADDR_WIDTH+1 bits.
- Pop accepted = read & (count != 0).
  - On acceptance: data_out <= mem[rd_ptr], rd_ptr++, valid_out <= 1.
  - Otherwise valid_out <= 0 and data_out holds its value.
  - Read latency is 1 cycle.
- Push accepted = write & ((count != depth) | pop accepted).
  - On acceptance: mem[wr_ptr] <= data_in, wr_ptr++.
  - A push while full succeeds only when a pop is accepted the same cycle.
- count next = count + push_acc - pop_acc; simultaneous accepted push and pop leave count unchanged.
- Simultaneous push and pop when count==0: only the push is accepted; the new word is not bypassed to data_out.
- Flags are decoded combinationally from the registered count, so they reflect occupancy after the last edge.
- Error events:
  - Overflow: write & ~push accepted.
  - Underflow: read & (count == 0).
  - On an error event, fifo_error <= 1 at the next edge (persistence per Optional Feature).
  - A rejected push never corrupts memory or pointers.
- Pause FSM, two states, evaluated on next-count:
  - RUN -> PAUSE when next count >= AF_THRESH.
  - PAUSE -> RUN when next count <= AE_THRESH.
  - All other cases hold state.
- fifo_pause = (state == PAUSE), registered; it stays asserted while occupancy drains from AF_THRESH down to AE_THRESH+1.
- Parameter constraint: AE_THRESH < AF_THRESH <= depth is required; violation is unsupported.

Optional Feature:
- Macro: FLOW_FIFO_STICKY_ERR_EN.
- Defined: fifo_error is sticky; once set it stays 1 until reset.
- Undefined: fifo_error is a single-cycle pulse, 1 for exactly the cycle after each error event and 0 otherwise.
- Overflow and underflow detection are identical in both builds.

Test Plan:
- Reset: hold reset=0 for 2 clk with write=read=1 -> count stays 0; fifo_empty=1, almost_empty=1, fifo_error=0, valid_out=0, fifo_pause=0.
- Fill: push 0x01..0x08 on 8 consecutive cycles:
  - almost_empty drops after the 3rd push.
  - almost_full and fifo_pause rise after the 6th.
  - Fifo_full rises after the 8th.
- Overflow: 9th push with read=0 -> word dropped, fifo_error=1 next cycle, contents unchanged. Sticky build holds fifo_error=1; pulse build returns it to 0 after one cycle.
- Drain and hysteresis: pop 8 times -> data_out 0x01..0x08 in order, each with valid_out=1 one cycle after its read.
  - fifo_pause stays 1 at counts 5, 4, 3 and falls when count reaches 2.
  - fifo_empty=1 after the 8th pop.
- Full simultaneous push and pop: at count=8, write=1, read=1, data_in=0x2A -> count stays 8, data_out=oldest word, no error. 0x2A emerges after 7 further pops, confirming pointer wrap.
- Underflow: read=1 at count=0 -> valid_out=0, data_out unchanged, fifo_error asserts the next cycle.
